// File: rtl/matrix_multiply_unit.sv
// Sequential signed matrix multiplier C = A x B with one MAC per clock.
// Shares the start/busy/done handshake of the transpose stage so the two can be chained.
module matrix_multiply_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int M_ROWS     = 2,
    parameter int K_DIM      = 3,
    parameter int N_COLS     = 2,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  op_start_mm,
    input  logic [M_ROWS*K_DIM*DATA_WIDTH-1:0]    matrix_a,
    input  logic [K_DIM*N_COLS*DATA_WIDTH-1:0]    matrix_b,
    output logic [M_ROWS*N_COLS*ACC_WIDTH-1:0]    matrix_c,
    output logic                                  op_busy_mm,
    output logic                                  op_done_mm
);

    localparam int I_W = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;
    localparam int J_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int K_W = (K_DIM  > 1) ? $clog2(K_DIM)  : 1;

    localparam logic [I_W-1:0] I_LAST = I_W'(M_ROWS - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_COLS - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K_DIM - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LATCH   = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Both operands are sign-extended to the accumulator width; the product wraps there.
    function automatic logic signed [ACC_WIDTH-1:0] mac_product(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH-1:0] ax;
        logic signed [ACC_WIDTH-1:0] bx;
        ax = {{(ACC_WIDTH-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
        bx = {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    logic [1:0]                   state_q, state_d;
    logic                         start_d1_q, start_d1_d;
    logic [I_W-1:0]               i_q, i_d;
    logic [J_W-1:0]               j_q, j_d;
    logic [K_W-1:0]               k_q, k_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] a_q [M_ROWS][K_DIM];
    logic signed [DATA_WIDTH-1:0] a_d [M_ROWS][K_DIM];
    logic signed [DATA_WIDTH-1:0] b_q [K_DIM][N_COLS];
    logic signed [DATA_WIDTH-1:0] b_d [K_DIM][N_COLS];
    logic signed [ACC_WIDTH-1:0]  c_q [M_ROWS][N_COLS];
    logic signed [ACC_WIDTH-1:0]  c_d [M_ROWS][N_COLS];
    logic signed [ACC_WIDTH-1:0]  sum;
    logic                         start_edge;

    assign start_edge = op_start_mm & ~start_d1_q;

    always_comb begin
        state_d    = state_q;
        start_d1_d = op_start_mm;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        sum        = acc_q + mac_product(a_q[i_q][k_q], b_q[k_q][j_q]);
        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_LATCH;
            end
            S_LATCH: begin
                for (int r = 0; r < M_ROWS; r++)
                    for (int c = 0; c < K_DIM; c++)
                        a_d[r][c] = matrix_a[(r*K_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
                for (int r = 0; r < K_DIM; r++)
                    for (int c = 0; c < N_COLS; c++)
                        b_d[r][c] = matrix_b[(r*N_COLS+c)*DATA_WIDTH +: DATA_WIDTH];
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                acc_d   = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (k_q != K_LAST) begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end else begin
                    // Last term of a dot product: commit it and walk row-major to the next element.
                    c_d[i_q][j_q] = sum;
                    acc_d         = '0;
                    k_d           = '0;
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (i_q == I_LAST) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_d1_q <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            a_q        <= '{default: '0};
            b_q        <= '{default: '0};
            c_q        <= '{default: '0};
        end else begin
            state_q    <= state_d;
            start_d1_q <= start_d1_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
        end
    end

    for (genvar r = 0; r < M_ROWS; r++) begin : g_row
        for (genvar c = 0; c < N_COLS; c++) begin : g_col
            assign matrix_c[(r*N_COLS+c)*ACC_WIDTH +: ACC_WIDTH] = c_q[r][c];
        end
    end

    assign op_busy_mm = (state_q == S_LATCH) || (state_q == S_COMPUTE);
    assign op_done_mm = (state_q == S_DONE);

endmodule
